// File: rtl/ov7670_sccb_sequencer_pkg.sv
// ov7670_pkg -- shared types and constants for the OV7670 SCCB configuration
// sequencer.
//   sccb_state_t     : sequencer FSM state encoding
//   SCCB_WRITE_ID    : SCCB slave write address of the OV7670
//   DELAY_TOKEN      : ROM word that requests a settle delay instead of a write
//   END_TOKEN        : ROM word that marks the end of the register table
//   sccb_write_word(): builds the 27-bit serial frame for one register write
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } sccb_state_t;

  localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
  localparam logic [15:0] DELAY_TOKEN   = 16'hFFF0;
  localparam logic [15:0] END_TOKEN     = 16'hFFFF;

  localparam int unsigned FRAME_BITS = 27;
  localparam logic [4:0]  LAST_BIT   = 5'd26;

  // Three 9-bit phases (id, sub-address, data), each followed by a
  // don't-care slot where the slave may drive its ACK.
  function automatic logic [26:0] sccb_write_word(input logic [15:0] cmd);
    return {SCCB_WRITE_ID, 1'b0, cmd[15:8], 1'b0, cmd[7:0], 1'b0};
  endfunction

  function automatic logic is_ack_slot(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_sccb_sequencer_if.sv
// ov7670_sccb_sequencer_if -- register-ROM handshake and SCCB pin bundle.
//   command/finished : current ROM word and its end-marker flag
//   advance/resend   : step the ROM forward / rewind it to word 0
//   restart          : rerun the whole configuration once finished
//   sioc/siod_out/siod_oe : SCCB clock, data value and data output enable
//   busy/config_done : sequencer status
// modport master = sequencer side, modport slave = ROM / pad side.
interface ov7670_sccb_sequencer_if;

  logic [15:0] command;
  logic        finished;
  logic        advance;
  logic        resend;
  logic        restart;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;
  logic        busy;
  logic        config_done;

  modport master (
    input  command, finished, restart,
    output advance, resend, sioc, siod_out, siod_oe, busy, config_done
  );

  modport slave (
    output command, finished, restart,
    input  advance, resend, sioc, siod_out, siod_oe, busy, config_done
  );

endinterface

// File: rtl/ov7670_sccb_sequencer_quarter_tick.sv
// sccb_quarter_tick -- SIOC quarter-period timebase.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   clear   : synchronous restart of the timebase (quarter 0, full period)
//   tick    : high for the last cycle of every CLK_DIV-cycle quarter
//   quarter : index of the quarter currently in progress (0..3)
module sccb_quarter_tick #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= DIV_LOAD;
      quarter <= 2'd0;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LOAD;
      quarter <= quarter + 2'd1;
    end else begin
      div_cnt <= div_cnt - CW'(1);
    end
  end

  assign tick = (div_cnt == '0);

endmodule

// File: rtl/ov7670_sccb_sequencer.sv
// ov7670_sccb_sequencer -- walks an external register ROM and writes each
// {reg_addr, reg_data} word to the OV7670 over SCCB (3-phase write).
// Delay tokens insert a settle wait; the end marker parks the sequencer.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : ov7670_sccb_sequencer_if.master (ROM handshake + SCCB pins)
//
// state  | meaning
// -------+-----------------------------------------------------------
// INIT   | one cycle, rewind ROM (resend)
// FETCH  | decode ROM word: end marker, delay token or register write
// START  | SCCB start condition (SIOD falls while SIOC high)
// BIT    | shift 27 frame bits out MSB first, ACK slots released
// STOP   | SCCB stop condition (SIOD released while SIOC high)
// GAP    | bus idle between transactions
// DELAY  | bus idle for DELAY_CYCLES, then consume the token
// DONE   | configuration complete, wait for restart
module ov7670_sccb_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 125,
  parameter int unsigned DELAY_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES   = 1000
) (
  input logic clk,
  input logic reset,
  ov7670_sccb_sequencer_if.master bus
);

  sccb_state_t state, state_next;
  logic [26:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [31:0] timer;
  logic        load_shift;
  logic        state_change;
  logic        tick;
  logic [1:0]  quarter;

  logic advance, resend, sioc, siod_out, siod_oe, busy, config_done;

  // Restarting the timebase on every state change keeps each state's
  // quarters aligned to its own entry cycle.
  assign state_change = (state_next != state);

  sccb_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_quarter_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_change),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_INIT;
      shift_q <= '1;
      bit_cnt <= '0;
      timer   <= '0;
    end else begin
      state <= state_next;

      if (load_shift) begin
        shift_q <= sccb_write_word(bus.command);
      end else if (state == ST_BIT && tick && quarter == 2'd3) begin
        shift_q <= {shift_q[25:0], 1'b1};
      end

      if (state_change) begin
        bit_cnt <= '0;
      end else if (state == ST_BIT && tick && quarter == 2'd3) begin
        bit_cnt <= bit_cnt + 5'd1;
      end

      // Idle-state timer: loaded on entry, terminal count at zero.
      if (state_change) begin
        if (state_next == ST_GAP) begin
          timer <= 32'(GAP_CYCLES - 1);
        end else if (state_next == ST_DELAY) begin
          timer <= 32'(DELAY_CYCLES - 1);
        end else begin
          timer <= '0;
        end
      end else if (timer != '0) begin
        timer <= timer - 32'd1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    load_shift  = 1'b0;
    advance     = 1'b0;
    resend      = 1'b0;
    sioc        = 1'b1;
    siod_out    = 1'b1;
    siod_oe     = 1'b0;
    busy        = 1'b1;
    config_done = 1'b0;

    unique case (state)
      ST_INIT: begin
        resend     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.finished) begin
          state_next = ST_DONE;
        end else if (bus.command == DELAY_TOKEN) begin
          state_next = ST_DELAY;
        end else begin
          load_shift = 1'b1;
          advance    = 1'b1;
          state_next = ST_START;
        end
      end

      ST_START: begin
        siod_oe  = 1'b1;
        siod_out = 1'b0;
        sioc     = (quarter == 2'd0);
        if (tick && quarter == 2'd1) state_next = ST_BIT;
      end

      ST_BIT: begin
        sioc     = quarter[1];
        siod_out = shift_q[26];
        siod_oe  = !is_ack_slot(bit_cnt);
        if (tick && quarter == 2'd3 && bit_cnt == LAST_BIT) state_next = ST_STOP;
      end

      ST_STOP: begin
        sioc     = (quarter != 2'd0);
        siod_out = 1'b0;
        siod_oe  = (quarter != 2'd2);
        if (tick && quarter == 2'd2) state_next = ST_GAP;
      end

      ST_GAP: begin
        if (timer == '0) state_next = ST_FETCH;
      end

      ST_DELAY: begin
        if (timer == '0) begin
          advance    = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_DONE: begin
        busy        = 1'b0;
        config_done = 1'b1;
        if (bus.restart) state_next = ST_INIT;
      end

      default: state_next = ST_INIT;
    endcase
  end

  assign bus.advance     = advance;
  assign bus.resend      = resend;
  assign bus.sioc        = sioc;
  assign bus.siod_out    = siod_out;
  assign bus.siod_oe     = siod_oe;
  assign bus.busy        = busy;
  assign bus.config_done = config_done;

endmodule

// File: tb/tb_ov7670_sccb_sequencer.sv
module tb_ov7670_sccb_sequencer;

  localparam int CLK_DIV      = 4;
  localparam int DELAY_CYCLES = 100;
  localparam int GAP_CYCLES   = 10;
  localparam int START_TO_GAP = 452;  // 113 * 4

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_clr = 1'b1;

  ov7670_sccb_sequencer_if bus ();

  ov7670_sccb_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .DELAY_CYCLES (DELAY_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register ROM model
  logic [15:0] rom [8];
  logic [2:0]  rom_addr = 3'd0;

  always @(posedge clk) begin
    if (bus.resend) rom_addr <= 3'd0;
    else if (bus.advance && rom_addr != 3'd7) rom_addr <= rom_addr + 3'd1;
  end

  assign bus.command  = rom[rom_addr];
  assign bus.finished = (bus.command == 16'hFFFF);

  // Bus monitor: samples every cycle just after the rising edge
  int cyc = 0;
  int adv_cnt, adv_cyc, resend_cnt, resend_cyc, sioc_edges, oe_cycles;
  int ntx, bitn, done_cyc;
  logic prev_sioc, prev_oe, prev_done;
  logic [26:0] tx_word [8];
  logic [26:0] tx_oe [8];
  int tx_start [8];

  always @(posedge clk) begin
    logic pin;
    #1;
    cyc = cyc + 1;
    pin = bus.siod_oe ? bus.siod_out : 1'b1;
    if (mon_clr) begin
      adv_cnt = 0; adv_cyc = 0; resend_cnt = 0; resend_cyc = 0;
      sioc_edges = 0; oe_cycles = 0; ntx = 0; bitn = 0; done_cyc = 0;
    end else begin
      if (bus.advance) begin adv_cnt++; adv_cyc = cyc; end
      if (bus.resend) begin resend_cnt++; resend_cyc = cyc; end
      if (bus.sioc != prev_sioc) sioc_edges++;
      if (bus.siod_oe) oe_cycles++;
      if (bus.config_done && !prev_done) done_cyc = cyc;
      if (bus.siod_oe && !prev_oe && bus.sioc && ntx < 8) begin
        tx_start[ntx] = cyc;
        tx_word[ntx]  = '0;
        tx_oe[ntx]    = '0;
        ntx++;
        bitn = 0;
      end else if (bus.sioc && !prev_sioc && ntx > 0 && bitn < 27) begin
        tx_word[ntx-1] = {tx_word[ntx-1][25:0], pin};
        tx_oe[ntx-1]   = {tx_oe[ntx-1][25:0], bus.siod_oe};
        bitn++;
      end
    end
    prev_sioc = bus.sioc;
    prev_oe   = bus.siod_oe;
    prev_done = bus.config_done;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    chk("rst_sioc", 32'(bus.sioc), 32'd1);
    chk("rst_siod_oe", 32'(bus.siod_oe), 32'd0);
    chk("rst_siod_out", 32'(bus.siod_out), 32'd1);
    chk("rst_advance", 32'(bus.advance), 32'd0);
    chk("rst_config_done", 32'(bus.config_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < hold; i++) @(negedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (bus.config_done) got = 1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic wait_bit(input int tx, input int nbits, input int budget, input string name);
    int got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (ntx >= tx && bitn >= nbits) got = 1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic chk_frame(input int idx, input logic [7:0] ea, input logic [7:0] ed, input string tag);
    logic [26:0] w;
    w = tx_word[idx];
    chk({tag, "_id"}, 32'(w[26:19]), 32'h42);
    chk({tag, "_addr"}, 32'(w[17:10]), 32'(ea));
    chk({tag, "_data"}, 32'(w[8:1]), 32'(ed));
    chk({tag, "_ack_pin"}, 32'({w[18], w[9], w[0]}), 32'h7);
    chk({tag, "_oe_map"}, 32'(tx_oe[idx]), 32'(27'b11111111_0_11111111_0_11111111_0));
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] seq_addr [3];
  logic [7:0] seq_data [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1204, 8'h12, 8'h04};
    vecs[1] = '{16'h1280, 8'h12, 8'h80};
    vecs[2] = '{16'h00FF, 8'h00, 8'hFF};
    vecs[3] = '{16'hFFF1, 8'hFF, 8'hF1};
    vecs[4] = '{16'hA55A, 8'hA5, 8'h5A};
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    bus.restart = 1'b0;

    // Single register writes
    for (int v = 0; v < 5; v++) begin
      rom[0] = vecs[v].cmd;
      rom[1] = 16'hFFFF;
      do_reset(1);
      wait_done(2000, "vec_done");
      chk("vec_adv_cnt", 32'(adv_cnt), 32'd1);
      chk("vec_ntx", 32'(ntx), 32'd1);
      chk("vec_bits", 32'(bitn), 32'd27);
      chk_frame(0, vecs[v].exp_addr, vecs[v].exp_data, "vec");
      chk("vec_adv_in_fetch", 32'(tx_start[0] - adv_cyc), 32'd1);
      chk("vec_start_to_gap", 32'(done_cyc - tx_start[0] - GAP_CYCLES - 1), 32'(START_TO_GAP));
      chk("vec_resend_cnt", 32'(resend_cnt), 32'd1);
      chk("vec_busy_done", 32'(bus.busy), 32'd0);
      chk("vec_sioc_done", 32'(bus.sioc), 32'd1);
    end

    // Delay token then end marker
    rom[0] = 16'hFFF0;
    rom[1] = 16'hFFFF;
    do_reset(0);
    wait_done(500, "dly_done");
    chk("dly_adv_cnt", 32'(adv_cnt), 32'd1);
    chk("dly_adv_cycle", 32'(adv_cyc - resend_cyc), 32'd101);
    chk("dly_done_cycle", 32'(done_cyc - adv_cyc), 32'd2);
    chk("dly_sioc_edges", 32'(sioc_edges), 32'd0);
    chk("dly_oe_cycles", 32'(oe_cycles), 32'd0);

    // End marker at the very first fetch
    rom[0] = 16'hFFFF;
    do_reset(2);
    wait_done(20, "fin_done");
    chk("fin_done_cycle", 32'(done_cyc - resend_cyc), 32'd2);
    chk("fin_adv_cnt", 32'(adv_cnt), 32'd0);
    chk("fin_sioc_edges", 32'(sioc_edges), 32'd0);
    chk("fin_resend_cnt", 32'(resend_cnt), 32'd1);

    // Reset during bit 13 of a write
    rom[0] = 16'h1204;
    rom[1] = 16'hFFFF;
    do_reset(0);
    wait_bit(1, 14, 400, "mid_reach_bit13");
    do_reset(0);
    wait_done(2000, "mid_done");
    chk("mid_resend_cnt", 32'(resend_cnt), 32'd1);
    chk("mid_fresh_fetch", 32'(tx_start[0] - resend_cyc), 32'd2);
    chk("mid_ntx", 32'(ntx), 32'd1);
    chk("mid_adv_cnt", 32'(adv_cnt), 32'd1);
    chk_frame(0, 8'h12, 8'h04, "mid");

    // Three writes, restart ignored mid-transfer, then restart from DONE
    rom[0] = 16'h1280; seq_addr[0] = 8'h12; seq_data[0] = 8'h80;
    rom[1] = 16'h3A04; seq_addr[1] = 8'h3A; seq_data[1] = 8'h04;
    rom[2] = 16'h40D0; seq_addr[2] = 8'h40; seq_data[2] = 8'hD0;
    rom[3] = 16'hFFFF;
    do_reset(0);
    wait_bit(2, 5, 2000, "seq_reach_tx2");
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    wait_done(5000, "seq_done");
    chk("seq_adv_cnt", 32'(adv_cnt), 32'd3);
    chk("seq_ntx", 32'(ntx), 32'd3);
    for (int t = 0; t < 3; t++) chk_frame(t, seq_addr[t], seq_data[t], "seq");

    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("rs_left_done", 32'(bus.config_done), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd1);
    wait_done(5000, "rs_done");
    chk("rs_resend_cnt", 32'(resend_cnt), 32'd1);
    chk("rs_adv_cnt", 32'(adv_cnt), 32'd3);
    chk("rs_ntx", 32'(ntx), 32'd3);
    for (int t = 0; t < 3; t++) chk_frame(t, seq_addr[t], seq_data[t], "rs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
